// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with a small receive FIFO.
// Deserializes bytes from rxd and buffers them. Exposes a data register and a
// status register with one-cycle registered-read timing.
// Ports:
//   clk       system clock
//   resetn    synchronous active-low reset
//   rxd       asynchronous serial input, idle high
//   sel_data  data register selected
//   sel_stat  status register selected
//   rstrb     read strobe
//   rdata     registered read data
//   rx_avail  FIFO non-empty, registered off the FIFO count
module uart_rx_ip #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rxd,
    input  logic        sel_data,
    input  logic        sel_stat,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        rx_avail
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W       = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2:0]          bitcnt, bitcnt_n;
    logic [7:0]          shreg, shreg_n;
    logic                push_c;
    logic                ferr_set_c;

    logic                rx_meta;
    logic                rxs;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [FCNT_W-1:0]   count;
    logic                ovr, ferr;

    logic                data_rd_c, stat_rd_c;
    logic                empty_c, full_c;
    logic                pop_c, wr_c, ovr_set_c;
    logic [31:0]         status_c;

    // Read decode; data wins if both selects are asserted.
    assign data_rd_c  = rstrb & sel_data;
    assign stat_rd_c  = rstrb & sel_stat & ~sel_data;
    assign empty_c    = (count == '0);
    assign full_c     = (count == FCNT_W'(FIFO_DEPTH));
    assign pop_c      = data_rd_c & ~empty_c;
    // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
    assign wr_c       = push_c & (~full_c | pop_c);
    assign ovr_set_c  = push_c & full_c & ~pop_c;
    assign status_c   = {24'b0, 4'(count), ferr, ovr, full_c, ~empty_c};

    // Receiver next-state: mid-bit sampling driven by a down-counter.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    cnt_n   = CNT_W'(HALF_BIT - 1);
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        cnt_n    = CNT_W'(CLKS_PER_BIT - 1);
                        bitcnt_n = 3'd0;
                        state_n  = S_DATA;
                    end else begin
                        state_n  = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n = {rxs, shreg[7:1]};
                    cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    if (bitcnt == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    push_c     = rxs;
                    ferr_set_c = ~rxs;
                    state_n    = S_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, synchronizer, FIFO control and read port registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bitcnt   <= 3'd0;
            shreg    <= 8'h00;
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            rdata    <= 32'h0;
            rx_avail <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            rx_meta  <= rxd;
            rxs      <= rx_meta;

            if (wr_c)  wptr <= wptr + PTR_W'(1);
            if (pop_c) rptr <= rptr + PTR_W'(1);
            case ({wr_c, pop_c})
                2'b10:   count <= count + FCNT_W'(1);
                2'b01:   count <= count - FCNT_W'(1);
                default: count <= count;
            endcase

            // Status read clears the sticky flags unless a new event sets them.
            ovr  <= (ovr  & ~stat_rd_c) | ovr_set_c;
            ferr <= (ferr & ~stat_rd_c) | ferr_set_c;

            if (rstrb) begin
                if (sel_data) begin
                    rdata <= empty_c ? 32'h0 : {24'b0, mem[rptr]};
                end else if (sel_stat) begin
                    rdata <= status_c;
                end else begin
                    rdata <= 32'h0;
                end
            end

            rx_avail <= ~empty_c;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_c) mem[wptr] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_ip.sv
// tb_uart_rx_ip: directed and randomized bench for uart_rx_ip.
// Serial frames are driven bit by bit; expected register values come from a
// byte-queue model of the receive FIFO plus two sticky flag bits.
module tb_uart_rx_ip;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxd;
    logic        sel_data;
    logic        sel_stat;
    logic        rstrb;
    logic [31:0] rdata;
    logic        rx_avail;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_ferr;

    uart_rx_ip #(
        .CLK_FREQ_HZ (1600),
        .BAUD_RATE   (100),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rxd      (rxd),
        .sel_data (sel_data),
        .sel_stat (sel_stat),
        .rstrb    (rstrb),
        .rdata    (rdata),
        .rx_avail (rx_avail)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input bit is_data, output logic [31:0] v);
        sel_data = is_data;
        sel_stat = !is_data;
        rstrb    = 1'b1;
        tick(1);
        rstrb    = 1'b0;
        sel_data = 1'b0;
        sel_stat = 1'b0;
        v        = rdata;
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] v, e;
        e = 32'h0;
        if (q.size() != 0) e = {24'b0, q.pop_front()};
        read_reg(1'b1, v);
        check(tag, v, e);
    endtask

    task automatic read_stat_chk(input string tag);
        logic [31:0] v, e;
        e = {24'b0, 4'(q.size()), m_ferr, m_ovr, (q.size() == DEPTH), (q.size() != 0)};
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        read_reg(1'b0, v);
        check(tag, v, e);
    endtask

    // Drives one 8N1 frame (10 bit times). With rd_at_push a data read is
    // issued in the cycle the receiver samples the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd_at_push);
        logic [9:0]  frm;
        logic [31:0] e;
        frm = {stop_ok, b, 1'b0};
        e   = 32'h0;
        if (rd_at_push && q.size() != 0) e = {24'b0, q.pop_front()};
        for (int c = 0; c < 10 * CPB; c++) begin
            rxd = frm[c / CPB];
            if (rd_at_push) begin
                rstrb    = (c == 154);
                sel_data = (c == 154);
            end
            if (rd_at_push && c == 155) check("push_pop_rdata", rdata, e);
            tick(1);
        end
        rxd = 1'b1;
        if (stop_ok) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] frm;
        int         n;
        int         m;
        bit         bad;

        resetn   = 1'b0;
        rxd      = 1'b1;
        sel_data = 1'b0;
        sel_stat = 1'b0;
        rstrb    = 1'b0;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(1);
        check("reset_rdata", rdata, 32'h0);
        check("reset_avail", 32'(rx_avail), 32'h0);

        // Single frame
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(4);
        check("a5_avail", 32'(rx_avail), 32'h1);
        read_stat_chk("a5_status");
        read_data_chk("a5_data");
        check("a5_avail_hold", 32'(rx_avail), 32'h1);
        tick(1);
        check("a5_avail_fall", 32'(rx_avail), 32'h0);
        read_stat_chk("a5_status_after");

        // Start-bit glitch
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        read_stat_chk("glitch_status");
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(4);
        read_data_chk("glitch_3c_data");
        read_stat_chk("glitch_status_after");

        // Five back-to-back frames overflow a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        tick(4);
        read_stat_chk("ovr_status");
        read_stat_chk("ovr_status_cleared");
        for (int i = 0; i < 5; i++) read_data_chk($sformatf("ovr_data%0d", i));

        // Framing error
        send_frame(8'h55, 1'b0, 1'b0);
        tick(20);
        read_stat_chk("ferr_status");
        read_stat_chk("ferr_status_cleared");

        // Full FIFO with a pop in the push cycle
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b1);
        tick(4);
        read_stat_chk("pushpop_status");
        for (int i = 0; i < 5; i++) read_data_chk($sformatf("pushpop_data%0d", i));

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                b   = 8'($urandom);
                bad = ($urandom_range(0, 9) == 0);
                send_frame(b, !bad, 1'b0);
                if (bad) tick(20);
            end
            tick(4);
            read_stat_chk($sformatf("rnd%0d_status", r));
            m = q.size() + 1;
            for (int k = 0; k < m; k++) read_data_chk($sformatf("rnd%0d_data%0d", r, k));
            read_stat_chk($sformatf("rnd%0d_status_end", r));
        end

        // Reset in the middle of a frame
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(4);
        read_stat_chk("prerst_status");
        frm = {1'b1, 8'hFF, 1'b0};
        for (int c = 0; c < 5 * CPB + 8; c++) begin
            rxd = frm[c / CPB];
            tick(1);
        end
        resetn = 1'b0;
        rxd    = 1'b1;
        tick(2);
        resetn = 1'b1;
        q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        tick(2);
        check("rst_rdata", rdata, 32'h0);
        check("rst_avail", 32'(rx_avail), 32'h0);
        tick(CPB * 8);
        read_stat_chk("rst_status");
        send_frame(8'h81, 1'b1, 1'b0);
        tick(4);
        read_data_chk("rst_81_data");
        read_stat_chk("rst_status_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
